alu_result_stage: RTL and testbench



---
 rtl/alu_result_stage_if.sv | 43 ++++
 rtl/alu_result_stage.sv | 147 ++++++++++++++
 tb/tb_alu_result_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: handshake and data bundle for alu_result_stage.
// The master side is the ALU datapath/upstream stage and the EX/MEM consumer;
// the slave side is the result stage itself.
// out_flags exists only when ALU_FLAGS_EN is defined.
interface alu_result_stage_if #(
    parameter int WIDTH   = 64,
    parameter int NUM_OPS = 8
);
    localparam int SEL_W = $clog2(NUM_OPS);

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         cntrl;
    logic [NUM_OPS*WIDTH-1:0] op_results;
    logic                     in_carry;
    logic                     in_overflow;
    logic                     flag_we;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_result;
`ifdef ALU_FLAGS_EN
    logic [3:0]               out_flags;
`endif

    modport master (
        output flush, in_valid, cntrl, op_results, in_carry, in_overflow,
               flag_we, out_ready,
        input  in_ready, out_valid, out_result
`ifdef ALU_FLAGS_EN
        , input out_flags
`endif
    );

    modport slave (
        input  flush, in_valid, cntrl, op_results, in_carry, in_overflow,
               flag_we, out_ready,
        output in_ready, out_valid, out_result
`ifdef ALU_FLAGS_EN
        , output out_flags
`endif
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: selects one of NUM_OPS results by opcode and holds it in
// a two-entry (main + skid) registered pipeline stage with valid/ready.
// Optional feature macro: ALU_FLAGS_EN adds the architectural NZCV flag
// register, which updates in output order on handshakes of entries that
// carry flag_we. Without it the carry/overflow/flag_we inputs are ignored.
module alu_result_stage #(
    parameter int WIDTH   = 64,
    parameter int NUM_OPS = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_result_stage_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_OPS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_outValid;
    logic             r_inReady;
    logic [WIDTH-1:0] r_mainData;
    logic [WIDTH-1:0] r_skidData;
    logic [WIDTH-1:0] w_selResult;
    logic             w_accept;
    logic             w_handshake;

`ifdef ALU_FLAGS_EN
    logic       r_mainCarry;
    logic       r_mainOvf;
    logic       r_mainFlagWe;
    logic       r_skidCarry;
    logic       r_skidOvf;
    logic       r_skidFlagWe;
    logic [3:0] r_flags;
`endif

    assign w_accept    = bus.in_valid && r_inReady;
    assign w_handshake = r_outValid && bus.out_ready;

    // Opcode mux; codes at or above NUM_OPS fall through to zero.
    always_comb begin
        w_selResult = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (bus.cntrl == SEL_W'(i)) begin
                w_selResult = bus.op_results[i*WIDTH +: WIDTH];
            end
        end
    end

    // Main/skid storage state machine plus in-order flag register update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b0;
            r_mainData <= '0;
            r_skidData <= '0;
`ifdef ALU_FLAGS_EN
            r_mainCarry  <= 1'b0;
            r_mainOvf    <= 1'b0;
            r_mainFlagWe <= 1'b0;
            r_skidCarry  <= 1'b0;
            r_skidOvf    <= 1'b0;
            r_skidFlagWe <= 1'b0;
            r_flags      <= 4'b0000;
`endif
        end else if (bus.flush) begin
            r_state    <= EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_inReady <= 1'b1;
                    if (w_accept) begin
                        r_mainData <= w_selResult;
`ifdef ALU_FLAGS_EN
                        r_mainCarry  <= bus.in_carry;
                        r_mainOvf    <= bus.in_overflow;
                        r_mainFlagWe <= bus.flag_we;
`endif
                        r_state    <= ONE;
                        r_outValid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && bus.out_ready) begin
                        r_mainData <= w_selResult;
`ifdef ALU_FLAGS_EN
                        r_mainCarry  <= bus.in_carry;
                        r_mainOvf    <= bus.in_overflow;
                        r_mainFlagWe <= bus.flag_we;
`endif
                        r_inReady <= 1'b1;
                    end else if (w_accept) begin
                        r_skidData <= w_selResult;
`ifdef ALU_FLAGS_EN
                        r_skidCarry  <= bus.in_carry;
                        r_skidOvf    <= bus.in_overflow;
                        r_skidFlagWe <= bus.flag_we;
`endif
                        r_state   <= FULL;
                        r_inReady <= 1'b0;
                    end else if (bus.out_ready) begin
                        r_state    <= EMPTY;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        r_mainData <= r_skidData;
`ifdef ALU_FLAGS_EN
                        r_mainCarry  <= r_skidCarry;
                        r_mainOvf    <= r_skidOvf;
                        r_mainFlagWe <= r_skidFlagWe;
`endif
                        r_state   <= ONE;
                        r_inReady <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= EMPTY;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
`ifdef ALU_FLAGS_EN
            if (w_handshake && r_mainFlagWe) begin
                r_flags <= {r_mainData[WIDTH-1], (r_mainData == '0),
                            r_mainCarry, r_mainOvf};
            end
`endif
        end
    end

    assign bus.in_ready   = r_inReady;
    assign bus.out_valid  = r_outValid;
    assign bus.out_result = r_mainData;
`ifdef ALU_FLAGS_EN
    assign bus.out_flags  = r_flags;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage.
// A second instance with NUM_OPS=6 exercises the out-of-range opcode case.
// Flag checks are compiled only when ALU_FLAGS_EN is defined.
module tb_alu_result_stage;
    logic clk;
    logic reset_n;
    int   nChecks;
    int   nErrors;

    alu_result_stage_if #(.WIDTH(64), .NUM_OPS(8)) bus  ();
    alu_result_stage_if #(.WIDTH(64), .NUM_OPS(6)) bus6 ();

    alu_result_stage #(.WIDTH(64), .NUM_OPS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    alu_result_stage #(.WIDTH(64), .NUM_OPS(6)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus6.slave)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        nChecks++; if (bus.out_result !== 64'h0) begin nErrors++; $display("[TB] FAIL reset_out_result: got %h expected 0", bus.out_result); end
        nChecks++; if (bus.in_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_in_ready_low: got %b expected 0", bus.in_ready); end
`ifdef ALU_FLAGS_EN
        nChecks++; if (bus.out_flags !== 4'b0000) begin nErrors++; $display("[TB] FAIL reset_flags: got %b expected 0000", bus.out_flags); end
`endif
        reset_n = 1'b1;
        tick();
        nChecks++; if (bus.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL reset_in_ready_release: got %b expected 1", bus.in_ready); end
        nChecks++; if (bus6.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL reset6_in_ready_release: got %b expected 1", bus6.in_ready); end
    endtask

    task automatic test_select_sweep();
        logic [63:0] expected;
        for (int i = 0; i < 8; i++) begin
            bus.op_results[i*64 +: 64] = 64'h1111_1111_1111_1111 * i;
        end
        bus.out_ready = 1'b1;
        bus.flag_we   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.cntrl    = 3'(i);
            bus.in_valid = 1'b1;
            tick();
            expected = 64'h1111_1111_1111_1111 * i;
            nChecks++; if (bus.out_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL sweep_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            nChecks++; if (bus.out_result !== expected) begin nErrors++; $display("[TB] FAIL sweep_result[%0d]: got %h expected %h", i, bus.out_result, expected); end
        end
        bus.in_valid = 1'b0;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL sweep_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.cntrl     = 3'd2;
        bus.flag_we   = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_results[2*64 +: 64] = 64'hAAAA;
        bus.in_valid  = 1'b1;
        tick();
        nChecks++; if (bus.out_result !== 64'hAAAA) begin nErrors++; $display("[TB] FAIL bp_A_out: got %h expected %h", bus.out_result, 64'hAAAA); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL bp_ready_one: got %b expected 1", bus.in_ready); end
        bus.op_results[2*64 +: 64] = 64'hBBBB;
        tick();
        nChecks++; if (bus.in_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL bp_ready_full: got %b expected 0", bus.in_ready); end
        nChecks++; if (bus.out_result !== 64'hAAAA) begin nErrors++; $display("[TB] FAIL bp_A_hold1: got %h expected %h", bus.out_result, 64'hAAAA); end
        bus.op_results[2*64 +: 64] = 64'hCCCC;
        tick();
        tick();
        nChecks++; if (bus.out_result !== 64'hAAAA) begin nErrors++; $display("[TB] FAIL bp_A_hold3: got %h expected %h", bus.out_result, 64'hAAAA); end
        nChecks++; if (bus.in_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL bp_ready_still_full: got %b expected 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.out_result !== 64'hBBBB) begin nErrors++; $display("[TB] FAIL bp_B_out: got %h expected %h", bus.out_result, 64'hBBBB); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL bp_ready_back: got %b expected 1", bus.in_ready); end
        tick();
        nChecks++; if (bus.out_result !== 64'hCCCC) begin nErrors++; $display("[TB] FAIL bp_C_out: got %h expected %h", bus.out_result, 64'hCCCC); end
        bus.op_results[2*64 +: 64] = 64'hDDDD;
        tick();
        nChecks++; if (bus.out_result !== 64'hDDDD) begin nErrors++; $display("[TB] FAIL bp_D_out: got %h expected %h", bus.out_result, 64'hDDDD); end
        nChecks++; if (bus.out_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL bp_D_valid: got %b expected 1", bus.out_valid); end
        bus.in_valid = 1'b0;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL bp_drain: got %b expected 0", bus.out_valid); end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags();
        bus.out_ready   = 1'b0;
        bus.cntrl       = 3'd3;
        bus.op_results[3*64 +: 64] = 64'h0;
        bus.in_carry    = 1'b1;
        bus.in_overflow = 1'b0;
        bus.flag_we     = 1'b1;
        bus.in_valid    = 1'b1;
        tick();
        nChecks++; if (bus.out_flags !== 4'b0000) begin nErrors++; $display("[TB] FAIL flags_before_hs: got %b expected 0000", bus.out_flags); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.out_flags !== 4'b0110) begin nErrors++; $display("[TB] FAIL flags_sub_zero: got %b expected 0110", bus.out_flags); end
        bus.out_ready = 1'b0;
        bus.cntrl     = 3'd4;
        bus.op_results[4*64 +: 64] = 64'h8000_0000_0000_0000;
        bus.in_carry  = 1'b0;
        bus.flag_we   = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        nChecks++; if (bus.out_result !== 64'h8000_0000_0000_0000) begin nErrors++; $display("[TB] FAIL flags_and_result: got %h expected %h", bus.out_result, 64'h8000_0000_0000_0000); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.out_flags !== 4'b0110) begin nErrors++; $display("[TB] FAIL flags_no_we: got %b expected 0110", bus.out_flags); end
        bus.cntrl       = 3'd5;
        bus.op_results[5*64 +: 64] = 64'h8000_0000_0000_0001;
        bus.in_carry    = 1'b0;
        bus.in_overflow = 1'b1;
        bus.flag_we     = 1'b1;
        bus.in_valid    = 1'b1;
        tick();
        nChecks++; if (bus.out_flags !== 4'b0110) begin nErrors++; $display("[TB] FAIL flags_pending: got %b expected 0110", bus.out_flags); end
        bus.in_valid = 1'b0;
        tick();
        nChecks++; if (bus.out_flags !== 4'b1001) begin nErrors++; $display("[TB] FAIL flags_neg_ovf: got %b expected 1001", bus.out_flags); end
        bus.flag_we = 1'b0;
    endtask
`endif

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.cntrl     = 3'd3;
        bus.op_results[3*64 +: 64] = 64'h0;
        bus.in_carry  = 1'b1;
        bus.flag_we   = 1'b1;
        bus.in_valid  = 1'b1;
        tick();
        tick();
        nChecks++; if (bus.in_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_setup_full: got %b expected 0", bus.in_ready); end
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_valid: got %b expected 0", bus.out_valid); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL flush_ready: got %b expected 1", bus.in_ready); end
`ifdef ALU_FLAGS_EN
        nChecks++; if (bus.out_flags !== 4'b1001) begin nErrors++; $display("[TB] FAIL flush_flags: got %b expected 1001", bus.out_flags); end
`endif
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.flag_we  = 1'b0;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL flush_no_accept: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        bus.cntrl     = 3'd6;
        bus.op_results[6*64 +: 64] = 64'h1234_5678_9ABC_DEF0;
        bus.in_valid  = 1'b1;
        tick();
        tick();
        nChecks++; if (bus.out_result !== 64'h1234_5678_9ABC_DEF0) begin nErrors++; $display("[TB] FAIL mid_setup: got %h expected %h", bus.out_result, 64'h1234_5678_9ABC_DEF0); end
        reset_n = 1'b0;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", bus.out_valid); end
        nChecks++; if (bus.out_result !== 64'h0) begin nErrors++; $display("[TB] FAIL mid_reset_result: got %h expected 0", bus.out_result); end
        nChecks++; if (bus.in_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL mid_reset_ready: got %b expected 0", bus.in_ready); end
`ifdef ALU_FLAGS_EN
        nChecks++; if (bus.out_flags !== 4'b0000) begin nErrors++; $display("[TB] FAIL mid_reset_flags: got %b expected 0000", bus.out_flags); end
`endif
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        nChecks++; if (bus.in_ready !== 1'b1) begin nErrors++; $display("[TB] FAIL mid_release_ready: got %b expected 1", bus.in_ready); end
        nChecks++; if (bus.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL mid_release_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_nonpow2();
        for (int i = 0; i < 6; i++) begin
            bus6.op_results[i*64 +: 64] = 64'hA0 + 64'(i);
        end
        bus6.out_ready = 1'b1;
        bus6.cntrl     = 3'd5;
        bus6.in_valid  = 1'b1;
        tick();
        nChecks++; if (bus6.out_result !== 64'hA5) begin nErrors++; $display("[TB] FAIL np2_sel5: got %h expected %h", bus6.out_result, 64'hA5); end
        bus6.cntrl = 3'd7;
        tick();
        nChecks++; if (bus6.out_result !== 64'h0) begin nErrors++; $display("[TB] FAIL np2_sel7: got %h expected 0", bus6.out_result); end
        nChecks++; if (bus6.out_valid !== 1'b1) begin nErrors++; $display("[TB] FAIL np2_valid7: got %b expected 1", bus6.out_valid); end
        bus6.cntrl = 3'd6;
        tick();
        nChecks++; if (bus6.out_result !== 64'h0) begin nErrors++; $display("[TB] FAIL np2_sel6: got %h expected 0", bus6.out_result); end
        bus6.in_valid = 1'b0;
        tick();
        nChecks++; if (bus6.out_valid !== 1'b0) begin nErrors++; $display("[TB] FAIL np2_drain: got %b expected 0", bus6.out_valid); end
    endtask

    // Drives every scenario in order, then prints the summary.
    initial begin
        nChecks = 0;
        nErrors = 0;
        reset_n = 1'b0;
        bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.cntrl = '0;
        bus.op_results = '0;  bus.in_carry = 1'b0;  bus.in_overflow = 1'b0;
        bus.flag_we = 1'b0;  bus.out_ready = 1'b0;
        bus6.flush = 1'b0; bus6.in_valid = 1'b0; bus6.cntrl = '0;
        bus6.op_results = '0; bus6.in_carry = 1'b0; bus6.in_overflow = 1'b0;
        bus6.flag_we = 1'b0; bus6.out_ready = 1'b0;

        test_reset();
        test_select_sweep();
        test_backpressure();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        test_flush();
        test_reset_midstream();
        test_nonpow2();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
